image_resize_bilinear_sched: RTL and testbench

//  Sequencer for the bilinear resize datapath. Walks the output raster and maps each output pixel to source

---
 rtl/image_resize_bilinear_sched_pkg.sv | 22 ++
 rtl/image_resize_bilinear_sched_if.sv | 49 ++++
 rtl/image_resize_bilinear_sched_coord_map.sv | 44 ++++
 rtl/image_resize_bilinear_sched.sv | 166 ++++++++++++++++
 tb/tb_image_resize_bilinear_sched.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/image_resize_bilinear_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_resize_pkg : shared defaults and FSM encoding for the resize sequencer|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package image_resize_pkg;

  localparam int DEF_CW     = 12;
  localparam int DEF_FRAC   = 8;
  localparam int DEF_RD_LAT = 1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t ROW_REQ = 3'd1;
  localparam state_t RUN     = 3'd2;
  localparam state_t ROW_END = 3'd3;
  localparam state_t DRAIN   = 3'd4;
  localparam state_t DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/image_resize_bilinear_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_resize_bilinear_sched_if : config, line-buffer and weight signals    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface image_resize_bilinear_sched_if
  import image_resize_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int FRAC = DEF_FRAC
);
  logic               start_i;
  logic [CW-1:0]      src_w_i;
  logic [CW-1:0]      src_h_i;
  logic [CW-1:0]      dst_w_i;
  logic [CW-1:0]      dst_h_i;
  logic [CW+FRAC-1:0] step_x_i;
  logic [CW+FRAC-1:0] step_y_i;
  logic               stall_i;
  logic               row_req_o;
  logic [CW-1:0]      row_y0_o;
  logic [CW-1:0]      row_y1_o;
  logic               row_ack_i;
  logic               rd_en_o;
  logic [CW-1:0]      rd_x0_o;
  logic [CW-1:0]      rd_x1_o;
  logic               cal_valid_o;
  logic [FRAC:0]      wx0_o;
  logic [FRAC:0]      wx1_o;
  logic [FRAC:0]      wy0_o;
  logic [FRAC:0]      wy1_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    input  start_i, src_w_i, src_h_i, dst_w_i, dst_h_i, step_x_i, step_y_i,
    input  stall_i, row_ack_i,
    output row_req_o, row_y0_o, row_y1_o, rd_en_o, rd_x0_o, rd_x1_o,
    output cal_valid_o, wx0_o, wx1_o, wy0_o, wy1_o, busy_o, done_o
  );

  modport slave (
    output start_i, src_w_i, src_h_i, dst_w_i, dst_h_i, step_x_i, step_y_i,
    output stall_i, row_ack_i,
    input  row_req_o, row_y0_o, row_y1_o, rd_en_o, rd_x0_o, rd_x1_o,
    input  cal_valid_o, wx0_o, wx1_o, wy0_o, wy1_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/image_resize_bilinear_sched_coord_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_resize_coord_map : fixed-point coordinate to tap pair and weights    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module image_resize_coord_map
  import image_resize_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int FRAC = DEF_FRAC
) (
  input  wire logic [CW+FRAC:0] acc,
  input  wire logic [CW-1:0]    src_dim,
  output logic      [CW-1:0]    p0,
  output logic      [CW-1:0]    p1,
  output logic      [FRAC:0]    w0,
  output logic      [FRAC:0]    w1
);
  localparam logic [FRAC:0] c_one = {1'b1, {FRAC{1'b0}}};

  logic [CW:0]     w_int;
  logic [FRAC-1:0] w_frac;
  logic [CW-1:0]   w_last;

  assign w_int  = acc[CW+FRAC:FRAC];
  assign w_frac = acc[FRAC-1:0];
  assign w_last = src_dim - 1'b1;

  // Past the last interior pair both taps collapse onto the edge pixel.
  always_comb begin
    if (w_int < {1'b0, w_last}) begin
      p0 = w_int[CW-1:0];
      p1 = w_int[CW-1:0] + 1'b1;
      w0 = c_one - {1'b0, w_frac};
      w1 = {1'b0, w_frac};
    end else begin
      p0 = w_last;
      p1 = w_last;
      w0 = c_one;
      w1 = '0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/image_resize_bilinear_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | image_resize_bilinear_sched : output-raster walker issuing line-buffer     |
// | reads and bilinear weights.  Rev 1.0                                       |
// +----------------------------------------------------------------------------+
module image_resize_bilinear_sched
  import image_resize_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int FRAC   = DEF_FRAC,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input wire logic clk,
  input wire logic reset,
  image_resize_bilinear_sched_if.master bus
);
  localparam int c_aw = CW + FRAC + 1;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_src_w, r_src_h, r_dst_w, r_dst_h, r_ox, r_oy, w_src_h_nxt;
  logic [CW+FRAC-1:0] r_step_x, r_step_y;
  logic [c_aw-1:0]    r_acc_x, r_acc_y, w_acc_y_nxt;
  logic               w_start, w_row_req, w_rd_en, w_done, w_busy;
  logic               r_row_req, r_rd_en, r_done, r_busy;
  logic [CW-1:0]      r_row_y0, r_row_y1, r_rd_x0, r_rd_x1;
  logic [FRAC:0]      r_wx0, r_wx1, r_wy0, r_wy1;
  logic [CW-1:0]      w_x_p0, w_x_p1, w_y_p0, w_y_p1;
  logic [FRAC:0]      w_x_w0, w_x_w1, w_y_w0, w_y_w1;
  logic [RD_LAT-1:0]  r_pv;
  logic [FRAC:0]      r_pwx0 [RD_LAT];
  logic [FRAC:0]      r_pwx1 [RD_LAT];
  logic [FRAC:0]      r_pwy0 [RD_LAT];
  logic [FRAC:0]      r_pwy1 [RD_LAT];

  function automatic logic [c_aw-1:0] sat_add(input logic [c_aw-1:0] a, input logic [CW+FRAC-1:0] b);
    logic [c_aw:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[c_aw] ? '1 : s[c_aw-1:0];
  endfunction

  assign w_start     = (r_state == IDLE) && bus.start_i;
  assign w_src_h_nxt = w_start ? bus.src_h_i : r_src_h;

  // The y map looks at the accumulator value the next row request will use.
  always_comb begin
    w_acc_y_nxt = r_acc_y;
    if (w_start)
      w_acc_y_nxt = '0;
    else if (r_state == ROW_END && w_state_nxt == ROW_REQ)
      w_acc_y_nxt = sat_add(r_acc_y, r_step_y);
  end

  image_resize_coord_map #(.CW(CW), .FRAC(FRAC)) u_map_x (
    .acc(r_acc_x), .src_dim(r_src_w), .p0(w_x_p0), .p1(w_x_p1), .w0(w_x_w0), .w1(w_x_w1)
  );

  image_resize_coord_map #(.CW(CW), .FRAC(FRAC)) u_map_y (
    .acc(w_acc_y_nxt), .src_dim(w_src_h_nxt), .p0(w_y_p0), .p1(w_y_p1), .w0(w_y_w0), .w1(w_y_w1)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start_i)
                 w_state_nxt = (bus.dst_w_i == '0 || bus.dst_h_i == '0) ? DONE : ROW_REQ;
      ROW_REQ: if (bus.row_ack_i) w_state_nxt = RUN;
      RUN:     if (!bus.stall_i && r_ox == r_dst_w - 1'b1) w_state_nxt = ROW_END;
      ROW_END: w_state_nxt = (r_oy == r_dst_h - 1'b1) ? DRAIN : ROW_REQ;
      DRAIN:   if (!r_rd_en && r_pv == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_row_req = (w_state_nxt == ROW_REQ);
    w_rd_en   = (r_state == RUN) && !bus.stall_i;
    w_done    = (r_state == DONE);
    w_busy    = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {r_src_w, r_src_h, r_dst_w, r_dst_h, r_ox, r_oy} <= '0;
      {r_step_x, r_step_y, r_acc_x, r_acc_y}           <= '0;
      {r_row_req, r_rd_en, r_done, r_busy}             <= '0;
      {r_row_y0, r_row_y1, r_rd_x0, r_rd_x1}           <= '0;
      {r_wx0, r_wx1, r_wy0, r_wy1}                     <= '0;
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pwx0[i] <= '0;
        r_pwx1[i] <= '0;
        r_pwy0[i] <= '0;
        r_pwy1[i] <= '0;
      end
    end else begin
      r_acc_y   <= w_acc_y_nxt;
      r_row_req <= w_row_req;
      r_rd_en   <= w_rd_en;
      r_done    <= w_done;
      r_busy    <= w_busy;
      if (w_start) begin
        r_src_w  <= bus.src_w_i;
        r_src_h  <= bus.src_h_i;
        r_dst_w  <= bus.dst_w_i;
        r_dst_h  <= bus.dst_h_i;
        r_step_x <= bus.step_x_i;
        r_step_y <= bus.step_y_i;
        r_oy     <= '0;
      end
      if (w_state_nxt == ROW_REQ) begin
        r_row_y0 <= w_y_p0;
        r_row_y1 <= w_y_p1;
      end
      if (r_state == ROW_REQ && bus.row_ack_i) begin
        r_acc_x <= '0;
        r_ox    <= '0;
        r_wy0   <= w_y_w0;
        r_wy1   <= w_y_w1;
      end
      if (w_rd_en) begin
        r_rd_x0 <= w_x_p0;
        r_rd_x1 <= w_x_p1;
        r_wx0   <= w_x_w0;
        r_wx1   <= w_x_w1;
        r_acc_x <= sat_add(r_acc_x, r_step_x);
        r_ox    <= r_ox + 1'b1;
      end
      if (r_state == ROW_END && w_state_nxt == ROW_REQ)
        r_oy <= r_oy + 1'b1;
      // Weights ride alongside the read so they meet the returning pixel data.
      r_pv[0]   <= r_rd_en;
      r_pwx0[0] <= r_wx0;
      r_pwx1[0] <= r_wx1;
      r_pwy0[0] <= r_wy0;
      r_pwy1[0] <= r_wy1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pwx0[i] <= r_pwx0[i-1];
        r_pwx1[i] <= r_pwx1[i-1];
        r_pwy0[i] <= r_pwy0[i-1];
        r_pwy1[i] <= r_pwy1[i-1];
      end
    end
  end

  assign bus.row_req_o   = r_row_req;
  assign bus.row_y0_o    = r_row_y0;
  assign bus.row_y1_o    = r_row_y1;
  assign bus.rd_en_o     = r_rd_en;
  assign bus.rd_x0_o     = r_rd_x0;
  assign bus.rd_x1_o     = r_rd_x1;
  assign bus.cal_valid_o = r_pv[RD_LAT-1];
  assign bus.wx0_o       = r_pwx0[RD_LAT-1];
  assign bus.wx1_o       = r_pwx1[RD_LAT-1];
  assign bus.wy0_o       = r_pwy0[RD_LAT-1];
  assign bus.wy1_o       = r_pwy1[RD_LAT-1];
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_image_resize_bilinear_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_image_resize_bilinear_sched : directed vectors for the resize sequencer |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_image_resize_bilinear_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  image_resize_bilinear_sched_if #(.CW(12), .FRAC(8)) bus ();

  image_resize_bilinear_sched #(.CW(12), .FRAC(8), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  int n_chk = 0, n_pass = 0;
  int n_iss = 0, n_cal = 0, n_req = 0, n_reqhi = 0, n_done = 0;
  int stall_viol = 0, req_viol = 0, sum_viol = 0;
  int ack_dly = 0;
  logic stall_mode = 1'b0;
  logic prev_stall = 1'b0;
  int iss_x0 [1024], iss_x1 [1024];
  int cal_wx0 [1024], cal_wx1 [1024], cal_wy0 [1024], cal_wy1 [1024];
  int req_y0 [256], req_y1 [256];

  int t1_x0 [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
  int t1_wx1 [8] = '{0, 128, 0, 128, 0, 128, 0, 0};
  int t1_y0 [8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
  int t2_x0 [4]  = '{0, 1, 2, 3};
  int t2_x1 [4]  = '{1, 2, 3, 3};
  int t3_x0 [3]  = '{0, 2, 5};
  int t3_x1 [3]  = '{1, 3, 6};
  int t3_wx0 [3] = '{256, 'h55, 'hAA};
  int t3_wx1 [3] = '{0, 'hAB, 'h56};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic run_frame(input logic [11:0] sw, input logic [11:0] sh, input logic [11:0] dw,
                           input logic [11:0] dh, input logic [19:0] stx, input logic [19:0] sty);
    @(posedge clk); #1;
    bus.src_w_i = sw;  bus.src_h_i = sh;
    bus.dst_w_i = dw;  bus.dst_h_i = dh;
    bus.step_x_i = stx; bus.step_y_i = sty;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = n_done;
    for (int i = 0; i < budget && n_done == base; i++) @(negedge clk);
    chk(tag, n_done != base, 1);
    repeat (4) @(negedge clk);
  endtask

  // Line buffer model: acknowledge each row request after ack_dly cycles.
  initial begin
    bus.row_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.row_req_o && !reset) begin
        repeat (ack_dly) @(posedge clk);
        #1 bus.row_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.row_ack_i = 1'b0;
      end
    end
  end

  initial begin
    bus.stall_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.stall_i = stall_mode ? ~bus.stall_i : 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.row_req_o) n_reqhi++;
        if (bus.row_req_o && bus.row_ack_i) begin
          if (n_req < 256) begin
            req_y0[n_req] = int'(bus.row_y0_o);
            req_y1[n_req] = int'(bus.row_y1_o);
          end
          n_req++;
        end
        if (bus.rd_en_o) begin
          if (bus.row_req_o) req_viol++;
          if (prev_stall) stall_viol++;
          if (n_iss < 1024) begin
            iss_x0[n_iss] = int'(bus.rd_x0_o);
            iss_x1[n_iss] = int'(bus.rd_x1_o);
          end
          n_iss++;
        end
        if (bus.cal_valid_o) begin
          if (n_cal < 1024) begin
            cal_wx0[n_cal] = int'(bus.wx0_o);
            cal_wx1[n_cal] = int'(bus.wx1_o);
            cal_wy0[n_cal] = int'(bus.wy0_o);
            cal_wy1[n_cal] = int'(bus.wy1_o);
          end
          if (int'(bus.wx0_o) + int'(bus.wx1_o) != 256 || int'(bus.wy0_o) + int'(bus.wy1_o) != 256)
            sum_viol++;
          n_cal++;
        end
        if (bus.done_o) n_done++;
      end
      prev_stall = bus.stall_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int b_iss, b_cal, b_req, b_done, b_sum, b_reqhi, bad;
    bus.start_i = 1'b0;
    bus.src_w_i = '0; bus.src_h_i = '0; bus.dst_w_i = '0; bus.dst_h_i = '0;
    bus.step_x_i = '0; bus.step_y_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_row_req", bus.row_req_o, 0);
    chk("rst_rd_en", bus.rd_en_o, 0);
    chk("rst_cal_valid", bus.cal_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);

    // 4x4 -> 8x8 upscale
    b_iss = n_iss; b_cal = n_cal; b_req = n_req; b_done = n_done; b_sum = sum_viol;
    run_frame(4, 4, 8, 8, 'h80, 'h80);
    chk("t1_busy", bus.busy_o, 1);
    wait_done("t1_done_seen", 2000);
    chk("t1_cal_cnt", n_cal - b_cal, 64);
    chk("t1_done_cnt", n_done - b_done, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_x0[%0d]", k), iss_x0[b_iss + k], t1_x0[k]);
      chk($sformatf("t1_wx1[%0d]", k), cal_wx1[b_cal + k], t1_wx1[k]);
      chk($sformatf("t1_y0[%0d]", k), req_y0[b_req + k], t1_y0[k]);
    end
    chk("t1_clamp_x1_6", iss_x1[b_iss + 6], 3);
    chk("t1_clamp_x1_7", iss_x1[b_iss + 7], 3);
    chk("t1_clamp_wx0_6", cal_wx0[b_cal + 6], 256);
    chk("t1_clamp_wx0_7", cal_wx0[b_cal + 7], 256);
    chk("t1_row1_wy1", cal_wy1[b_cal + 8], 128);
    chk("t1_sum", sum_viol - b_sum, 0);

    // 4x4 -> 4x4 identity, with a second start while busy
    b_iss = n_iss; b_cal = n_cal; b_req = n_req; b_done = n_done;
    run_frame(4, 4, 4, 4, 'h100, 'h100);
    run_frame(4, 4, 8, 8, 'h80, 'h80);
    wait_done("t2_done_seen", 2000);
    repeat (20) @(negedge clk);
    chk("t2_cal_cnt", n_cal - b_cal, 16);
    chk("t2_done_cnt", n_done - b_done, 1);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (iss_x0[b_iss + k] != t2_x0[k % 4] || iss_x1[b_iss + k] != t2_x1[k % 4]) bad++;
      if (cal_wx0[b_cal + k] != 256 || cal_wx1[b_cal + k] != 0 ||
          cal_wy0[b_cal + k] != 256 || cal_wy1[b_cal + k] != 0) bad++;
    end
    chk("t2_pattern_bad", bad, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("t2_y0[%0d]", k), req_y0[b_req + k], k);
    chk("t2_y1_last", req_y1[b_req + 3], 3);

    // 8x8 -> 3x3 downscale
    b_iss = n_iss; b_cal = n_cal; b_req = n_req; b_sum = sum_viol;
    run_frame(8, 8, 3, 3, 'h2AB, 'h2AB);
    wait_done("t3_done_seen", 2000);
    chk("t3_cal_cnt", n_cal - b_cal, 9);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_x0[%0d]", k), iss_x0[b_iss + k], t3_x0[k]);
      chk($sformatf("t3_x1[%0d]", k), iss_x1[b_iss + k], t3_x1[k]);
      chk($sformatf("t3_wx0[%0d]", k), cal_wx0[b_cal + k], t3_wx0[k]);
      chk($sformatf("t3_wx1[%0d]", k), cal_wx1[b_cal + k], t3_wx1[k]);
      chk($sformatf("t3_y0[%0d]", k), req_y0[b_req + k], t3_x0[k]);
    end
    chk("t3_row2_wy1", cal_wy1[b_cal + 6], 'h56);
    chk("t3_sum", sum_viol - b_sum, 0);

    // Slow acknowledge and alternating stall
    ack_dly = 5; stall_mode = 1'b1;
    b_iss = n_iss; b_cal = n_cal; b_sum = sum_viol;
    run_frame(4, 4, 4, 4, 'h100, 'h100);
    wait_done("t4_done_seen", 3000);
    ack_dly = 0; stall_mode = 1'b0;
    chk("t4_iss_cnt", n_iss - b_iss, 16);
    chk("t4_cal_cnt", n_cal - b_cal, 16);
    chk("t4_stall_viol", stall_viol, 0);
    chk("t4_req_viol", req_viol, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_x0[%0d]", k), iss_x0[b_iss + k], t2_x0[k]);

    // Zero output width
    b_iss = n_iss; b_reqhi = n_reqhi; b_done = n_done;
    @(posedge clk); #1;
    bus.dst_w_i = '0; bus.dst_h_i = 12'd4; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk); chk("t5_done_c1", bus.done_o, 0);
    @(negedge clk); chk("t5_done_c2", bus.done_o, 1);
    @(negedge clk); chk("t5_done_c3", bus.done_o, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_req", n_reqhi - b_reqhi, 0);
    chk("t5_no_rd", n_iss - b_iss, 0);
    chk("t5_done_cnt", n_done - b_done, 1);

    // Reset in the middle of a row
    b_iss = n_iss; b_done = n_done;
    run_frame(4, 4, 8, 8, 'h80, 'h80);
    for (int i = 0; i < 200 && n_iss < b_iss + 3; i++) @(negedge clk);
    chk("t6_reached_run", n_iss >= b_iss + 3, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rd_en", bus.rd_en_o, 0);
    chk("t6_row_req", bus.row_req_o, 0);
    chk("t6_cal_valid", bus.cal_valid_o, 0);
    chk("t6_busy", bus.busy_o, 0);
    chk("t6_done", bus.done_o, 0);
    @(posedge clk); #1 reset = 1'b0;
    b_iss = n_iss; b_reqhi = n_reqhi;
    repeat (20) @(negedge clk);
    chk("t6_no_rd", n_iss - b_iss, 0);
    chk("t6_no_req", n_reqhi - b_reqhi, 0);
    chk("t6_no_done", n_done - b_done, 0);
    b_iss = n_iss; b_cal = n_cal; b_sum = sum_viol; b_done = n_done;
    run_frame(4, 4, 4, 4, 'h100, 'h100);
    wait_done("t6_clean_done_seen", 2000);
    chk("t6_clean_cal_cnt", n_cal - b_cal, 16);
    chk("t6_clean_done_cnt", n_done - b_done, 1);
    chk("t6_clean_x1_0", iss_x1[b_iss], 1);
    chk("t6_clean_sum", sum_viol - b_sum, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
